pmem_arbiter: RTL
=================

// Module: pmem_arbiter
// PURPOSE
//  Shares one physical-memory line port between the instruction cache (read-only)
//  and the data cache (read/write). Sits between both caches' pmem_* sides and
//  main memory/L2. Grants one requester per transaction and latches its address
//  and write data. Routes pmem_resp back only to the granted cache.
// PARAMETERS
//  s_offset  5    line offset bits; the address sent to memory has [s_offset-1:0] forced to 0
//  s_line    256  line width in bits for rdata/wdata
// PORTS
//  clk             in   1       clock, rising edge
//  rst             in   1       asynchronous reset, active-low
//  i_pmem_read     in   1       I-cache line read request
//  i_pmem_address  in   32      I-cache line address
//  i_pmem_rdata    out  s_line  line data to I-cache
//  i_pmem_resp     out  1       I-cache transaction done
//  d_pmem_read     in   1       D-cache line read request
//  d_pmem_write    in   1       D-cache line write-back request
//  d_pmem_address  in   32      D-cache line address
//  d_pmem_wdata    in   s_line  D-cache write-back line
//  d_pmem_rdata    out  s_line  line data to D-cache
//  d_pmem_resp     out  1       D-cache transaction done
//  pmem_read       out  1       memory read strobe
//  pmem_write      out  1       memory write strobe
//  pmem_address    out  32      memory line address (registered)
//  pmem_wdata      out  s_line  memory write data (registered)
//  pmem_rdata      in   s_line  memory read data
//  pmem_resp       in   1       memory transaction done
// BEHAVIOUR
//  - FSM states: IDLE, SERVE_I, SERVE_D. Reset enters IDLE.
//  - Reset state: pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, both resp=0.
//    Reset is async. Asserting it mid-transaction drops the strobes immediately and discards the owner.
//  - IDLE: no strobes. On the clock edge, sample the requests.
//    - D-cache requests (read|write) and I-cache is idle: go to SERVE_D.
//    - Only the I-cache requests: go to SERVE_I.
//    - Both request: winner is chosen per CONFIGURATION.
//    - On grant: latch {address & ~(2**s_offset-1)}. For SERVE_D, also latch wdata and the op.
//  - D op latching: d_pmem_write=1 latches WRITE, else READ. If read and write are both high, WRITE wins.
//  - SERVE_x: drive pmem_read or pmem_write from the latched op, constant until pmem_resp.
//    The latched address/wdata stay stable even if the cache inputs change.
//  - Response routing: x_pmem_resp = pmem_resp while in SERVE_x (combinational, same cycle).
//    The non-owner resp is always 0.
//  - Read data: pmem_rdata is broadcast to both *_rdata, which is valid only when the matching resp=1.
//  - Transition: a cycle with pmem_resp=1 returns to IDLE at the next edge.
//    Min occupancy is grant edge -> >=1 SERVE cycle -> 1 IDLE cycle.
//    The mandatory IDLE gap lets the finished cache drop its request, so it is never re-granted.
//  - Latency added per transaction: 1 cycle (the IDLE sample) before the strobe. Zero on the response.
//  - A pmem_resp seen in IDLE is ignored: no resp forwarded, no state change.
//  - A request withdrawn mid-SERVE is illegal. The arbiter completes the latched transaction regardless.
// CONFIGURATION
//  - PMEM_ARB_ROUND_ROBIN_EN defined: a 1-bit last-owner register (reset = I).
//    On a tie, grant the cache that did NOT own the previous transaction.
//    It is updated at every grant.
//  - Not defined: fixed priority. The D-cache always wins a tie, and no last-owner register exists.
//  - Single-requester behaviour is identical in both builds.
// TESTING
//  1 Reset: rst=0 mid SERVE_D with pmem_write=1 -> strobes 0 same cycle. After release, state IDLE.
//  2 I read: i_pmem_read=1, addr 0x0000_1234 -> next cycle pmem_read=1, pmem_address=0x0000_1220.
//    pmem_resp after 3 cycles -> i_pmem_resp=1 that cycle, d_pmem_resp=0, then IDLE.
//  3 D write-back: d_pmem_write=1, addr 0x8000_0040, wdata={8{32'hDEADBEEF}} -> pmem_write=1 with that data.
//    Change d inputs mid-wait -> pmem_address/wdata unchanged.
//  4 Tie, fixed priority: both request at once -> D served first, I granted after the gap.
//    Repeat back-to-back -> D wins every tie.
//  5 Tie, PMEM_ARB_ROUND_ROBIN_EN: three consecutive ties after reset.
//    -> grant order D, I, D (last owner reset = I), each ending with the correct resp only.
//  6 Stray pmem_resp=1 in IDLE -> no resp out, no strobe, state stays IDLE.

Source files
------------

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory line port between the I-cache and the D-cache.
// Optional tie-break: define PMEM_ARB_ROUND_ROBIN_EN for round robin, else D wins.
module pmem_arbiter #(
  parameter int s_offset = 5,
  parameter int s_line   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [31:0]       i_pmem_address,
  output logic [s_line-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [31:0]       d_pmem_address,
  input  logic [s_line-1:0] d_pmem_wdata,
  output logic [s_line-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam logic [31:0] line_mask =
    ~((32'd1 << s_offset) - 32'd1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              d_req;
  logic              i_req;
  logic              tie_to_d;
  logic              grant_d;
  logic              grant_i;
  logic              wr_q;
  logic [31:0]       addr_q;
  logic [s_line-1:0] wdata_q;

  assign d_req = d_pmem_read | d_pmem_write;
  assign i_req = i_pmem_read;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  // 1 = the D-cache owned the previous transaction
  logic last_d_q;

  assign tie_to_d = ~last_d_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d_q <= 1'b0;
    end else if (grant_d) begin
      last_d_q <= 1'b1;
    end else if (grant_i) begin
      last_d_q <= 1'b0;
    end
  end
`else
  assign tie_to_d = 1'b1;
`endif

  assign grant_d = (state_q == IDLE) & d_req &
                   (~i_req | tie_to_d);
  assign grant_i = (state_q == IDLE) & i_req &
                   ~grant_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = SERVE_D;
        end else if (grant_i) begin
          state_d = SERVE_I;
        end
      end
      SERVE_I: begin
        pmem_read   = 1'b1;
        i_pmem_resp = pmem_resp;
        if (pmem_resp) begin
          state_d = IDLE;
        end
      end
      SERVE_D: begin
        pmem_read   = ~wr_q;
        pmem_write  = wr_q;
        d_pmem_resp = pmem_resp;
        if (pmem_resp) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request fields are captured once at grant and held for the whole transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else if (grant_d) begin
      addr_q  <= d_pmem_address & line_mask;
      wdata_q <= d_pmem_wdata;
      wr_q    <= d_pmem_write;
    end else if (grant_i) begin
      addr_q  <= i_pmem_address & line_mask;
    end
  end

  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule
